// File: rtl/cart_mem_pkg.sv
// Shared types for the cartridge memory arbiter: FSM state, grant id,
// default address width and a grant-to-ack one-hot helper.
package cart_mem_pkg;

  localparam int CART_ADDR_W = 22;

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, DONE} state_e;

  typedef enum logic [1:0] {GNT_NONE, GNT_PPU, GNT_CPU, GNT_LD} gnt_e;

  // Ack vector layout is {ld, cpu, ppu}.
  function automatic logic [2:0] gnt_onehot(input gnt_e g);
    case (g)
      GNT_PPU: return 3'b001;
      GNT_CPU: return 3'b010;
      GNT_LD:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/cart_mem_arbiter_if.sv
// Requester + memory-controller bundle for cart_mem_arbiter.
// slave  : arbiter view (takes requests and mem_ready/mem_rdata, drives acks and the mem command)
// master : environment view (requesters and memory controller)
interface cart_mem_arbiter_if
  import cart_mem_pkg::*;
#(
  parameter int ADDR_W = CART_ADDR_W
);
  logic              ppu_req;
  logic [ADDR_W-1:0] ppu_addr;
  logic              ppu_ack;
  logic [7:0]        ppu_rdata;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_ack;
  logic [7:0]        cpu_rdata;

  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        ld_wdata;
  logic              ld_ack;
  logic [7:0]        ld_rdata;

  logic              mem_valid;
  logic              mem_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport slave (
    input  ppu_req, ppu_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    input  mem_ready, mem_rdata,
    output ppu_ack, ppu_rdata, cpu_ack, cpu_rdata, ld_ack, ld_rdata,
    output mem_valid, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output ppu_req, ppu_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ld_req, ld_we, ld_addr, ld_wdata,
    output mem_ready, mem_rdata,
    input  ppu_ack, ppu_rdata, cpu_ack, cpu_rdata, ld_ack, ld_rdata,
    input  mem_valid, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cart_mem_prio.sv
// Combinational priority selector.
// i_ppu_req/i_cpu_req/i_ld_req : request levels
// i_promote                    : loader has been starved, lift it above CPU
// o_gnt                        : winning requester (GNT_NONE if no request)
module cart_mem_prio
  import cart_mem_pkg::*;
(
  input  logic i_ppu_req,
  input  logic i_cpu_req,
  input  logic i_ld_req,
  input  logic i_promote,
  output gnt_e o_gnt
);
  always_comb begin
    o_gnt = GNT_NONE;
    if (i_ppu_req)                 o_gnt = GNT_PPU;
    else if (i_promote && i_ld_req) o_gnt = GNT_LD;
    else if (i_cpu_req)            o_gnt = GNT_CPU;
    else if (i_ld_req)             o_gnt = GNT_LD;
  end
endmodule

// File: rtl/cart_mem_arbiter.sv
// Shares one cartridge memory port between PPU CHR fetch, CPU PRG access and
// the ROM loader. One transaction at a time: IDLE arbitrates and latches the
// command, ISSUE holds it until mem_ready, RDWAIT counts out the read
// latency, DONE pulses the winner's ack.
// clk_master/rst_master_n : clock, async active-low reset
// bus                     : requester handshakes + memory command port
// busy                    : high whenever a transaction is in flight
module cart_mem_arbiter
  import cart_mem_pkg::*;
#(
  parameter int ADDR_W       = CART_ADDR_W,
  parameter int RD_LATENCY   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               clk_master,
  input  logic               rst_master_n,
  cart_mem_arbiter_if.slave  bus,
  output logic               busy
);
  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  state_e            r_state;
  gnt_e              r_gnt;
  logic [CNT_W-1:0]  r_lat;
  logic [STV_W-1:0]  r_starve;
  logic              r_mem_valid;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;
  logic [2:0]        r_ack;
  logic [7:0]        r_ppu_rdata;
  logic [7:0]        r_cpu_rdata;
  logic [7:0]        r_ld_rdata;

  logic              w_promote;
  gnt_e              w_win;

  assign w_promote = (r_starve == STV_W'(STARVE_LIMIT));

  cart_mem_prio u_prio (
    .i_ppu_req (bus.ppu_req),
    .i_cpu_req (bus.cpu_req),
    .i_ld_req  (bus.ld_req),
    .i_promote (w_promote),
    .o_gnt     (w_win)
  );

  always_ff @(posedge clk_master or negedge rst_master_n) begin
    if (!rst_master_n) begin
      r_state     <= IDLE;
      r_gnt       <= GNT_NONE;
      r_lat       <= '0;
      r_starve    <= '0;
      r_mem_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_ack       <= '0;
      r_ppu_rdata <= '0;
      r_cpu_rdata <= '0;
      r_ld_rdata  <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        IDLE: begin
          if (w_win != GNT_NONE) begin
            r_gnt       <= w_win;
            r_mem_valid <= 1'b1;
            r_state     <= ISSUE;
            case (w_win)
              GNT_PPU: begin
                r_mem_we    <= 1'b0;
                r_mem_addr  <= bus.ppu_addr;
                r_mem_wdata <= '0;
              end
              GNT_CPU: begin
                r_mem_we    <= bus.cpu_we;
                r_mem_addr  <= bus.cpu_addr;
                r_mem_wdata <= bus.cpu_wdata;
              end
              default: begin
                r_mem_we    <= bus.ld_we;
                r_mem_addr  <= bus.ld_addr;
                r_mem_wdata <= bus.ld_wdata;
              end
            endcase
            // Loader losses age it; saturating at the limit keeps it promoted
            // until it actually wins.
            if (w_win == GNT_LD)
              r_starve <= '0;
            else if (bus.ld_req && !w_promote)
              r_starve <= r_starve + 1'b1;
          end
        end
        ISSUE: begin
          if (bus.mem_ready) begin
            r_mem_valid <= 1'b0;
            if (r_mem_we) begin
              r_ack   <= gnt_onehot(r_gnt);
              r_state <= DONE;
            end else begin
              r_lat   <= CNT_W'(RD_LATENCY - 1);
              r_state <= RDWAIT;
            end
          end
        end
        RDWAIT: begin
          if (r_lat == '0) begin
            case (r_gnt)
              GNT_PPU: r_ppu_rdata <= bus.mem_rdata;
              GNT_CPU: r_cpu_rdata <= bus.mem_rdata;
              GNT_LD:  r_ld_rdata  <= bus.mem_rdata;
              default: ;
            endcase
            r_ack   <= gnt_onehot(r_gnt);
            r_state <= DONE;
          end else begin
            r_lat <= r_lat - 1'b1;
          end
        end
        DONE: begin
          // Ack is high this cycle; no new command until back in IDLE.
          r_gnt   <= GNT_NONE;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy          = (r_state != IDLE);
  assign bus.mem_valid = r_mem_valid;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.ppu_ack   = r_ack[0];
  assign bus.cpu_ack   = r_ack[1];
  assign bus.ld_ack    = r_ack[2];
  assign bus.ppu_rdata = r_ppu_rdata;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.ld_rdata  = r_ld_rdata;

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Bench for cart_mem_arbiter: directed scenarios plus randomized traffic,
// all cross-checked every cycle by a transaction-level model.
module tb_cart_mem_arbiter;
  import cart_mem_pkg::*;

  localparam int AW = 22;
  localparam int RL = 2;
  localparam int SL = 8;
  typedef logic [AW-1:0] addr_t;

  logic clk_master   = 1'b0;
  logic rst_master_n = 1'b0;
  logic busy;

  cart_mem_arbiter_if #(.ADDR_W(AW)) bus ();

  cart_mem_arbiter #(.ADDR_W(AW), .RD_LATENCY(RL), .STARVE_LIMIT(SL)) dut (
    .clk_master   (clk_master),
    .rst_master_n (rst_master_n),
    .bus          (bus),
    .busy         (busy)
  );

  always #5 clk_master = ~clk_master;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents: written bytes, else a fixed function of the address.
  logic [7:0] mem [addr_t];
  function automatic logic [7:0] rd_mem(input addr_t a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h3C;
  endfunction

  function automatic bit req_of(input int k);
    case (k)
      0:       return bus.ppu_req;
      1:       return bus.cpu_req;
      default: return bus.ld_req;
    endcase
  endfunction

  // ---------------- transaction-level reference model ----------------
  // Requester ids: 0 PPU, 1 CPU, 2 loader.
  int         cyc = 0;
  bit         m_busy, m_issue;
  int         m_gnt, m_ack_cyc, m_starve;
  logic       m_we;
  addr_t      m_addr;
  logic [7:0] m_wdata, m_exp;
  logic [7:0] m_rd [3];
  int         ord [3];
  logic [2:0] e_ack, a_ack;
  typedef struct { int due; logic [7:0] d; } rdq_t;
  rdq_t rdq [$];

  initial begin
    forever begin
      @(negedge clk_master);
      cyc++;
      if (!rst_master_n) begin
        m_busy = 0; m_issue = 0; m_gnt = -1; m_starve = 0; m_ack_cyc = -1;
        m_rd = '{8'h00, 8'h00, 8'h00};
        rdq.delete();
        bus.mem_rdata = 8'h00;
        continue;
      end
      e_ack = 3'b000;
      if (m_busy && !m_issue && cyc == m_ack_cyc) begin
        e_ack[m_gnt] = 1'b1;
        if (!m_we) m_rd[m_gnt] = m_exp;
      end
      a_ack = {bus.ld_ack, bus.cpu_ack, bus.ppu_ack};
      chk("m busy", busy, m_busy);
      chk("m mem_valid", bus.mem_valid, m_busy && m_issue);
      chk("m acks", a_ack, e_ack);
      chk("m ppu_rdata", bus.ppu_rdata, m_rd[0]);
      chk("m cpu_rdata", bus.cpu_rdata, m_rd[1]);
      chk("m ld_rdata", bus.ld_rdata, m_rd[2]);
      if (m_busy && m_issue) begin
        chk("m mem_addr", bus.mem_addr, m_addr);
        chk("m mem_we", bus.mem_we, m_we);
        if (m_we) chk("m mem_wdata", bus.mem_wdata, m_wdata);
      end
      // advance
      if (!m_busy) begin
        if (bus.ppu_req || bus.cpu_req || bus.ld_req) begin
          if (m_starve >= SL) ord = '{0, 2, 1};
          else                ord = '{0, 1, 2};
          m_gnt = -1;
          foreach (ord[k]) if (m_gnt < 0 && req_of(ord[k])) m_gnt = ord[k];
          if (m_gnt == 2) m_starve = 0;
          else if (bus.ld_req && m_starve < SL) m_starve++;
          case (m_gnt)
            0: begin m_we = 1'b0;       m_addr = bus.ppu_addr; m_wdata = 8'h00; end
            1: begin m_we = bus.cpu_we; m_addr = bus.cpu_addr; m_wdata = bus.cpu_wdata; end
            default: begin m_we = bus.ld_we; m_addr = bus.ld_addr; m_wdata = bus.ld_wdata; end
          endcase
          m_busy = 1; m_issue = 1;
        end
      end else if (m_issue) begin
        if (bus.mem_ready) begin
          m_issue = 0;
          if (m_we) begin
            mem[m_addr] = m_wdata;
            m_ack_cyc = cyc + 1;
          end else begin
            m_exp = rd_mem(m_addr);
            rdq.push_back('{cyc + RL, m_exp});
            m_ack_cyc = cyc + 1 + RL;
          end
        end
      end else if (cyc == m_ack_cyc) begin
        m_busy = 0;
      end
      // memory read-data pins: real data only in the cycle it is due
      if (rdq.size() > 0 && rdq[0].due == cyc) begin
        bus.mem_rdata = rdq[0].d;
        void'(rdq.pop_front());
      end else begin
        bus.mem_rdata = 8'($urandom);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  typedef struct packed {
    logic v; logic we; addr_t a; logic [7:0] wd; logic [2:0] ack;
    logic [7:0] rp; logic [7:0] rc; logic [7:0] rl;
  } snap_t;

  logic [2:0] auto_drop = 3'b111;

  // Sample outputs mid-cycle, then move to just after the next edge.
  task automatic step(output snap_t s);
    @(negedge clk_master);
    s.v = bus.mem_valid; s.we = bus.mem_we; s.a = bus.mem_addr; s.wd = bus.mem_wdata;
    s.ack = {bus.ld_ack, bus.cpu_ack, bus.ppu_ack};
    s.rp = bus.ppu_rdata; s.rc = bus.cpu_rdata; s.rl = bus.ld_rdata;
    @(posedge clk_master); #1;
    if (s.ack[0] && auto_drop[0]) bus.ppu_req = 1'b0;
    if (s.ack[1] && auto_drop[1]) bus.cpu_req = 1'b0;
    if (s.ack[2] && auto_drop[2]) bus.ld_req  = 1'b0;
  endtask

  task automatic rand_req(input int k);
    addr_t      a = addr_t'($urandom_range(0, 63));
    logic [7:0] d = 8'($urandom);
    logic       w = 1'($urandom_range(0, 1));
    case (k)
      0: begin bus.ppu_req = 1'b1; bus.ppu_addr = a; end
      1: begin bus.cpu_req = 1'b1; bus.cpu_addr = a; bus.cpu_we = w; bus.cpu_wdata = d; end
      default: begin bus.ld_req = 1'b1; bus.ld_addr = a; bus.ld_we = w; bus.ld_wdata = d; end
    endcase
  endtask

  task automatic drop_req(input int k);
    case (k)
      0: bus.ppu_req = 1'b0;
      1: bus.cpu_req = 1'b0;
      default: bus.ld_req = 1'b0;
    endcase
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    snap_t s;
    int n, vcount, p_n, c_n, cpu_acks, k;
    bit got, any_ack;
    int rate [3] = '{15, 40, 40};

    bus.ppu_req = 0; bus.ppu_addr = '0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ld_req  = 0; bus.ld_we  = 0; bus.ld_addr  = '0; bus.ld_wdata  = '0;
    bus.mem_ready = 1'b1;

    // reset state
    repeat (3) @(posedge clk_master);
    @(negedge clk_master); #1;
    chk("reset busy", busy, 0);
    chk("reset mem_valid", bus.mem_valid, 0);
    chk("reset mem_addr", bus.mem_addr, 0);
    chk("reset acks", {bus.ld_ack, bus.cpu_ack, bus.ppu_ack}, 0);
    chk("reset rdata", {bus.ppu_rdata, bus.cpu_rdata, bus.ld_rdata}, 0);
    #1 rst_master_n = 1'b1;
    @(posedge clk_master); #1;

    // 1: single PPU read, ready tied high
    mem[22'h100010] = 8'h5A;
    bus.ppu_addr = 22'h100010; bus.ppu_req = 1'b1;
    vcount = 0; got = 0;
    for (n = 1; n <= 12; n++) begin
      step(s);
      if (s.v) begin vcount++; chk("t1 mem_addr", s.a, 22'h100010); end
      if (s.ack[0]) begin got = 1; chk("t1 ack cycle", n, 5); chk("t1 ppu_rdata", s.rp, 8'h5A); end
    end
    chk("t1 valid cycles", vcount, 1);
    chk("t1 ack seen", got, 1);

    // 2: PPU and CPU requested together
    mem[22'h000040] = 8'hC3;
    bus.ppu_addr = 22'h000200; bus.ppu_req = 1'b1;
    bus.cpu_addr = 22'h000040; bus.cpu_we = 1'b0; bus.cpu_req = 1'b1;
    p_n = 0; c_n = 0;
    for (n = 1; n <= 20; n++) begin
      step(s);
      if (s.ack[0]) p_n = n;
      if (s.ack[1]) begin c_n = n; chk("t2 cpu_rdata", s.rc, 8'hC3); end
    end
    chk("t2 ppu ack cycle", p_n, 5);
    chk("t2 cpu ack cycle", c_n, 10);

    // 3: loader write vs a CPU that never lets go
    auto_drop = 3'b101;
    bus.cpu_addr = 22'h002000; bus.cpu_we = 1'b0; bus.cpu_req = 1'b1;
    bus.ld_addr = 22'h000123; bus.ld_we = 1'b1; bus.ld_wdata = 8'hA5; bus.ld_req = 1'b1;
    cpu_acks = 0; got = 0;
    for (n = 0; n < 200 && !got; n++) begin
      step(s);
      if (s.v && s.we) begin
        chk("t3 ld mem_addr", s.a, 22'h000123);
        chk("t3 ld mem_wdata", s.wd, 8'hA5);
      end
      if (s.ack[1]) cpu_acks++;
      if (s.ack[2]) got = 1;
    end
    bus.cpu_req = 1'b0;
    auto_drop = 3'b111;
    chk("t3 ld ack seen", got, 1);
    chk("t3 cpu wins before loader", cpu_acks, 8);
    chk("t3 starve cleared", dut.r_starve, 0);
    chk("t3 mem written", rd_mem(22'h000123), 8'hA5);
    repeat (3) step(s);

    // 4: CPU write stalled by mem_ready, requester inputs wander meanwhile
    bus.mem_ready = 1'b0;
    bus.cpu_addr = 22'h0ABCDE; bus.cpu_we = 1'b1; bus.cpu_wdata = 8'h3C; bus.cpu_req = 1'b1;
    got = 0;
    for (n = 0; n < 10 && !got; n++) begin step(s); got = s.v; end
    chk("t4 issued", got, 1);
    for (int i = 0; i < 10; i++) begin
      bus.cpu_addr = addr_t'($urandom); bus.cpu_wdata = 8'($urandom);
      step(s);
      chk("t4 stall valid", s.v, 1);
      chk("t4 stall addr", s.a, 22'h0ABCDE);
      chk("t4 stall wdata", s.wd, 8'h3C);
      chk("t4 stall no ack", s.ack, 0);
    end
    bus.mem_ready = 1'b1;
    k = 0; got = 0;
    while (k < 6 && !got) begin step(s); k++; got = s.ack[1]; end
    chk("t4 ack after ready", k, 2);
    chk("t4 mem written", rd_mem(22'h0ABCDE), 8'h3C);
    repeat (2) step(s);

    // 5: reset while a CPU read waits for data
    bus.cpu_addr = 22'h000777; bus.cpu_we = 1'b0; bus.cpu_req = 1'b1;
    got = 0;
    for (n = 0; n < 10 && !got; n++) begin step(s); got = s.v; end
    chk("t5 issued", got, 1);
    chk("t5 in rdwait busy", busy, 1);
    bus.cpu_req = 1'b0;
    #2 rst_master_n = 1'b0;
    #1;
    chk("t5 async busy", busy, 0);
    chk("t5 async mem_valid", bus.mem_valid, 0);
    chk("t5 async mem_addr", bus.mem_addr, 0);
    chk("t5 async acks", {bus.ld_ack, bus.cpu_ack, bus.ppu_ack}, 0);
    chk("t5 async rdata", {bus.ppu_rdata, bus.cpu_rdata, bus.ld_rdata}, 0);
    chk("t5 state idle", dut.r_state, IDLE);
    repeat (2) @(posedge clk_master);
    @(negedge clk_master); #2 rst_master_n = 1'b1;
    @(posedge clk_master); #1;
    any_ack = 0;
    repeat (8) begin step(s); any_ack |= |s.ack; end
    chk("t5 no ack for aborted read", any_ack, 0);
    mem[22'h000321] = 8'h99;
    bus.ppu_addr = 22'h000321; bus.ppu_req = 1'b1;
    got = 0;
    for (n = 1; n <= 10; n++) begin
      step(s);
      if (s.ack[0]) begin got = 1; chk("t5 post-reset ack cycle", n, 5); chk("t5 post-reset rdata", s.rp, 8'h99); end
    end
    chk("t5 post-reset ack seen", got, 1);

    // 6: random traffic, checked by the model every cycle
    auto_drop = 3'b000;
    for (int i = 0; i < 4000; i++) begin
      step(s);
      for (int r = 0; r < 3; r++) begin
        if (s.ack[r]) begin
          if ($urandom_range(0, 3) == 0) rand_req(r);
          else drop_req(r);
        end else if (!req_of(r)) begin
          if ($urandom_range(0, 99) < rate[r]) rand_req(r);
        end else if ($urandom_range(0, 7) == 0) begin
          rand_req(r);
        end
      end
      bus.mem_ready = ($urandom_range(0, 3) != 0);
    end
    for (int r = 0; r < 3; r++) drop_req(r);
    bus.mem_ready = 1'b1;
    repeat (12) step(s);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cart_mem_arbiter.md
Name: cart_mem_arbiter

Overview:
- Shares one external cartridge memory port (BRAM/SDRAM controller front-end holding PRG and CHR images) between three requesters: PPU CHR fetch, CPU PRG access, and the ROM loader/debug port.
- Sits in the clk_master domain between the nes top-level cart_* pins and the memory controller.
- Grants one transaction at a time: PPU has fixed top priority; CPU and loader use anti-starvation aging.

Parameters:
- ADDR_W, 22, unified cartridge byte address width (PRG and CHR regions are pre-mapped by requesters)
- RD_LATENCY, 2, cycles from memory accept (mem_valid & mem_ready) to mem_rdata valid; fixed, ≥1
- STARVE_LIMIT, 8, number of consecutive lost arbitrations after which the loader is promoted above CPU

Ports:
- clk_master  in  1  master clock
- rst_master_n  in  1  asynchronous active-low reset
- ppu_req  in  1  PPU request, level, held until ppu_ack
- ppu_addr  in  ADDR_W  PPU address
- ppu_ack  out  1  one-cycle pulse; ppu_rdata valid this cycle
- ppu_rdata  out  8  read data
- cpu_req  in  1  CPU request, level
- cpu_we  in  1  CPU write enable
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  8  read data
- ld_req  in  1  loader request, level
- ld_we  in  1  loader write enable
- ld_addr  in  ADDR_W  loader address
- ld_wdata  in  8  loader write data
- ld_ack  out  1  one-cycle completion pulse
- ld_rdata  out  8  read data
- mem_valid  out  1  command valid
- mem_ready  in  1  controller accepts command
- mem_we  out  1  command is write
- mem_addr  out  ADDR_W  command address
- mem_wdata  out  8  write data
- mem_rdata  in  8  read data, valid RD_LATENCY cycles after accept
- busy  out  1  high whenever state ≠ IDLE

Behaviour:
- Reset (async, rst_master_n low): state=IDLE; mem_valid, mem_we, all *_ack, busy = 0; mem_addr, mem_wdata, all *_rdata = 0; starve counter = 0; grant = none.
- FSM states: IDLE, ISSUE, RDWAIT, DONE.
- IDLE: if any request is high, select the winner, register its addr/we/wdata into the mem_* outputs, record grant, go to ISSUE with mem_valid=1 next cycle.
- Priority: PPU > CPU > loader. When starve counter == STARVE_LIMIT, order is PPU > loader > CPU.
- Starve counter: increments (saturating at STARVE_LIMIT) each arbitration where ld_req is high but another requester wins; clears when the loader is granted.
- ISSUE: hold mem_valid and command stable until mem_ready. On accept: mem_valid=0. A write goes to DONE; a read goes to RDWAIT with latency counter = RD_LATENCY-1.
- RDWAIT: decrement the counter. At 0, capture mem_rdata into the granted requester's *_rdata, then go to DONE.
- DONE: pulse the granted *_ack for exactly one cycle, then return to IDLE. Writes also pulse ack and leave *_rdata unchanged.
- Minimum transaction: 3 cycles for a write with mem_ready already high; 3+RD_LATENCY cycles for a read.
- The arbiter issues no new command in the DONE cycle. The requester must drop req in the cycle after ack, or the request is treated as a new one.
- Simultaneous requests: only the winner is served. Losers keep req asserted and are re-arbitrated in the next IDLE.
- A req deasserted mid-transaction is ignored: the transaction completes and ack still pulses.
- Addresses and data are sampled only in IDLE. Later changes to requester inputs do not affect the in-flight command.
- Ungranted *_ack stays 0. *_rdata holds its last captured value.
- mem_ready is ignored outside ISSUE.

Decomposition:
- Package cart_mem_pkg: enum typedef for the state (IDLE/ISSUE/RDWAIT/DONE), enum for grant id (GNT_NONE/GNT_PPU/GNT_CPU/GNT_LD), and the default ADDR_W localparam.
- One sub-module, cart_mem_prio: combinational priority selector. Inputs: the three reqs and the promote flag. Output: grant id.
- Counters and the FSM stay in the top.

Test Plan:
- PPU read, RD_LATENCY=2, mem_ready tied 1, ppu_addr=0x100010, memory returns 0x5A → mem_valid one cycle with mem_addr=0x100010; ppu_ack pulses on cycle 5 after req; ppu_rdata=0x5A.
- cpu_req and ppu_req raised in the same cycle → PPU served first; CPU served next with no idle gap beyond the DONE→IDLE cycle; cpu_ack never coincides with ppu_ack.
- Loader write 0xA5 to 0x000123 while CPU continuously requests → after 8 lost arbitrations the loader wins; mem_we=1, mem_wdata=0xA5; ld_ack pulses; starve counter returns to 0.
- mem_ready held low 10 cycles during a CPU write → mem_valid, mem_addr and mem_wdata stay stable all 10 cycles; cpu_ack arrives 2 cycles after mem_ready rises.
- rst_master_n asserted while in RDWAIT → outputs clear asynchronously; state is IDLE; no ack is ever produced for the aborted read; the first request after release is handled normally.
- Requester changes cpu_addr after grant → mem_addr retains the value sampled in IDLE.
